piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, number of parallel bits per word (legal range 1..32).
REQ-002 SHALL provide parameter MSB_FIRST, default 1, serial bit order (1 = bit WIDTH-1 first, 0 = bit 0 first).
REQ-003 SHALL provide port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port din  input  WIDTH  parallel word to serialize.
REQ-006 SHALL provide port load  input  1  load request, sampled with din.
REQ-007 SHALL provide port ready  output  1  block can accept a word this cycle.
REQ-008 SHALL provide port sout  output  1  serial data bit.
REQ-009 SHALL provide port sout_valid  output  1  sout carries a valid bit this cycle.
REQ-010 SHALL provide port done  output  1  one-cycle pulse after the last bit of a word.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 SHALL, in IDLE, drive ready=1, sout_valid=0, sout=0, done=0.
REQ-013 SHALL accept a word when load=1 and ready=1 on a rising edge: capture din into the shift register, clear the bit counter, and enter SHIFT.
REQ-014 SHALL present the first serial bit on the cycle immediately after acceptance (latency 1 cycle).
REQ-015 SHALL, in SHIFT, drive sout_valid=1 and one new bit per cycle, in the order set by MSB_FIRST, for exactly WIDTH consecutive cycles.
REQ-016 SHALL use a bit counter of width clog2(WIDTH+1), incremented once per emitted bit, with no wrap beyond WIDTH.
REQ-017 SHALL move from SHIFT to DONE after bit WIDTH is emitted, drive done=1, sout_valid=0, sout=0 and ready=0 for exactly one cycle, then return to IDLE.
REQ-018 SHALL drive ready=0 throughout SHIFT and DONE, and SHALL ignore load in those states with no effect on the data or the count.
REQ-019 SHALL ignore changes on din after acceptance; the serial output depends only on the captured word.
REQ-020 SHALL support back-to-back words: with load held at 1, the next word is accepted on the first IDLE cycle after DONE (period WIDTH+2 cycles).
REQ-021 SHALL, for WIDTH=1, emit one bit, then DONE, then IDLE, with no special-case timing.
REQ-022 SHALL register ready, sout, sout_valid and done (no combinational path from inputs to outputs).

Reset
REQ-023 SHALL, while rst=1 on a rising edge, force state to IDLE, clear the shift register and the counter, and drive ready=0, sout=0, sout_valid=0, done=0.
REQ-024 SHALL drive ready=1 on the first cycle after rst is deasserted.
REQ-025 SHALL discard any word that is mid-shift when rst is asserted, and SHALL not generate a done pulse for it.
REQ-026 SHALL give rst priority over load when both are asserted on the same edge.

Structure
REQ-027 SHALL take its FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) from a shared header/package, together with the defaults for WIDTH and MSB_FIRST.
REQ-028 SHALL build each shift-register stage from one sub-module, mux2_dff_sync: a 2:1 mux (load vs. shift select) feeding a flop with synchronous active-high reset.
REQ-029 SHALL keep the FSM, the counter and the output registers in the top module.

Verification
REQ-030 SHALL cover this case: MSB_FIRST=1, WIDTH=8, load 8'hA5 at cycle 0 -> sout 1,0,1,0,0,1,0,1 with sout_valid=1 in cycles 1-8; done=1 in cycle 9; ready=1 in cycle 10.
REQ-031 SHALL cover this case: MSB_FIRST=0, load 8'h01 -> sout 1 in cycle 1 and 0 in cycles 2-8; done in cycle 9.
REQ-032 SHALL cover this case: load 8'hFF accepted, then load=1 with din=8'h00 in cycles 3-5 -> all eight bits are 1, ready stays 0, and there is a single done pulse.
REQ-033 SHALL cover this case: rst=1 on the edge after bit 4 of 8'hA5 -> sout_valid=0 and done=0 thereafter, no done pulse, and ready=1 on the first cycle after rst is released.
REQ-034 SHALL cover this case: load held at 1 with words 8'h3C then 8'hC3 -> the second word starts on sout exactly 10 cycles after the first, and both serialize correctly.
REQ-035 SHALL cover this case: WIDTH=1, load 1'b1 -> sout=1 with sout_valid=1 in cycle 1, done in cycle 2, ready in cycle 3.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer:
// FSM state encodings and parameter defaults.
package piso_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH     = 8;
  localparam bit DEFAULT_MSB_FIRST = 1'b1;

  // Counter must hold 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_serializer_mux2_dff_sync.sv
// One shift-register stage: 2:1 mux (shift vs. load) into a flop with
// synchronous active-high reset.
module mux2_dff_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_sel,
  input  logic i_d0,
  input  logic i_d1,
  output logic o_q
);

  logic r_q;

  // Stage flop: reset, else load (i_sel=1) or shift (i_sel=0).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 1'b0;
    end else begin
      r_q <= i_sel ? i_d1 : i_d0;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer: accepts a WIDTH-bit word when ready,
// emits it one bit per cycle, then pulses done for one cycle.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = DEFAULT_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int CW    = cnt_width(WIDTH);
  localparam int FIRST = MSB_FIRST ? WIDTH - 1 : 0;

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_ready;
  logic            r_sout;
  logic            r_valid;
  logic            r_done;

  logic [WIDTH-1:0] w_sreg;
  logic [WIDTH-1:0] w_up_sreg;
  logic [WIDTH-1:0] w_up_din;
  logic             w_accept;

  assign w_accept = r_ready & load & ~rst;

  // The first bit goes straight from din to the output register, so the
  // register holds the word already advanced by one position; each stage
  // takes its upstream neighbour on both the load and the shift path.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    if (MSB_FIRST) begin : g_msb
      if (i == 0) begin : g_edge
        assign w_up_sreg[i] = 1'b0;
        assign w_up_din[i]  = 1'b0;
      end else begin : g_mid
        assign w_up_sreg[i] = w_sreg[i-1];
        assign w_up_din[i]  = din[i-1];
      end
    end else begin : g_lsb
      if (i == WIDTH - 1) begin : g_edge
        assign w_up_sreg[i] = 1'b0;
        assign w_up_din[i]  = 1'b0;
      end else begin : g_mid
        assign w_up_sreg[i] = w_sreg[i+1];
        assign w_up_din[i]  = din[i+1];
      end
    end

    mux2_dff_sync u_stage (
      .clk  (clk),
      .rst  (rst),
      .i_sel(w_accept),
      .i_d0 (w_up_sreg[i]),
      .i_d1 (w_up_din[i]),
      .o_q  (w_sreg[i])
    );
  end

  // FSM, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_ready <= 1'b0;
      r_sout  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state <= ST_SHIFT;
            r_cnt   <= {CW{1'b0}};
            r_ready <= 1'b0;
            r_valid <= 1'b1;
            r_sout  <= din[FIRST];
          end else begin
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_sout  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_ready <= 1'b0;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= ST_DONE;
            r_cnt   <= CW'(WIDTH);
            r_valid <= 1'b0;
            r_sout  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
            r_sout  <= w_sreg[FIRST];
            r_valid <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
          r_sout  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= {CW{1'b0}};
          r_ready <= 1'b0;
          r_valid <= 1'b0;
          r_sout  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready      = r_ready;
  assign sout       = r_sout;
  assign sout_valid = r_valid;
  assign done       = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Three serializer configurations driven in lockstep and compared every cycle
// against a transaction-timeline reference model.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] din;
  logic [2:0] rdy_v, sout_v, val_v, done_v;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_m8 (
    .clk(clk), .rst(rst), .din(din), .load(load),
    .ready(rdy_v[0]), .sout(sout_v[0]), .sout_valid(val_v[0]), .done(done_v[0]));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_l8 (
    .clk(clk), .rst(rst), .din(din), .load(load),
    .ready(rdy_v[1]), .sout(sout_v[1]), .sout_valid(val_v[1]), .done(done_v[1]));

  piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_dut_w1 (
    .clk(clk), .rst(rst), .din(din[0:0]), .load(load),
    .ready(rdy_v[2]), .sout(sout_v[2]), .sout_valid(val_v[2]), .done(done_v[2]));

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          wid[3]   = '{8, 8, 1};
  bit          msb[3]   = '{1'b1, 1'b0, 1'b1};
  int          acc[3]   = '{-1, -1, -1};
  logic [31:0] word[3];
  int          last_rst = -100;
  int          cyc      = 0;
  logic [7:0]  recv_m   = 8'h00;
  int          done_cnt = 0;
  int          vstart[$];
  logic        prev_v0  = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A word accepted in cycle t owns cycles t+1..t+W (bits), t+W+1 (done);
  // the block is ready again from t+W+2, and two cycles after a reset cycle.
  function automatic bit m_ready(int d, int c);
    return (c >= last_rst + 2) && (acc[d] < 0 || c >= acc[d] + wid[d] + 2);
  endfunction

  function automatic bit m_valid(int d, int c);
    return (acc[d] >= 0) && (c >= acc[d] + 1) && (c <= acc[d] + wid[d]);
  endfunction

  function automatic bit m_sout(int d, int c);
    int k;
    int idx;
    if (!m_valid(d, c)) return 1'b0;
    k   = c - acc[d] - 1;
    idx = msb[d] ? (wid[d] - 1 - k) : k;
    return word[d][idx];
  endfunction

  function automatic bit m_done(int d, int c);
    return (acc[d] >= 0) && (c == acc[d] + wid[d] + 1);
  endfunction

  task automatic step(input logic r, input logic l, input logic [7:0] d);
    rst  = r;
    load = l;
    din  = d;
    if (r) begin
      last_rst = cyc;
      for (int i = 0; i < 3; i++) acc[i] = -1;
    end else if (l) begin
      for (int i = 0; i < 3; i++) begin
        if (m_ready(i, cyc)) begin
          acc[i]  = cyc;
          word[i] = (wid[i] == 1) ? {31'd0, d[0]} : {24'd0, d};
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      chk_eq($sformatf("ready[%0d]@%0d", i, cyc), {31'd0, rdy_v[i]},  {31'd0, m_ready(i, cyc)});
      chk_eq($sformatf("valid[%0d]@%0d", i, cyc), {31'd0, val_v[i]},  {31'd0, m_valid(i, cyc)});
      chk_eq($sformatf("sout[%0d]@%0d",  i, cyc), {31'd0, sout_v[i]}, {31'd0, m_sout(i, cyc)});
      chk_eq($sformatf("done[%0d]@%0d",  i, cyc), {31'd0, done_v[i]}, {31'd0, m_done(i, cyc)});
    end
    if (val_v[0] === 1'b1) recv_m = {recv_m[6:0], sout_v[0]};
    if (done_v[0] === 1'b1) done_cnt++;
    if (val_v[0] === 1'b1 && prev_v0 !== 1'b1) vstart.push_back(cyc);
    prev_v0 = val_v[0];
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    din  = 8'h00;

    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'hFF);
    step(1'b0, 1'b0, 8'h00);

    // 8'hA5: MSB-first stream, and 1'b1 into the single-bit instance
    recv_m = 8'h00;
    step(1'b0, 1'b1, 8'hA5);
    repeat (10) step(1'b0, 1'b0, 8'($urandom));
    chk_eq("a5_stream", {24'd0, recv_m}, 32'h0000_00A5);

    step(1'b0, 1'b1, 8'h01);
    repeat (10) step(1'b0, 1'b0, 8'($urandom));

    // load ignored while shifting
    done_cnt = 0;
    recv_m   = 8'h00;
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b0, 8'h00);
    repeat (3) step(1'b0, 1'b1, 8'h00);
    repeat (7) step(1'b0, 1'b0, 8'h00);
    chk_eq("ff_stream", {24'd0, recv_m}, 32'h0000_00FF);
    chk_eq("ff_done_count", done_cnt, 32'd1);

    // reset after the fourth bit discards the word
    done_cnt = 0;
    step(1'b0, 1'b1, 8'hA5);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    repeat (12) step(1'b0, 1'b0, 8'h00);
    chk_eq("rst_no_done", done_cnt, 32'd0);

    // back-to-back words with load held
    vstart.delete();
    recv_m = 8'h00;
    step(1'b0, 1'b1, 8'h3C);
    repeat (10) step(1'b0, 1'b1, 8'hC3);
    repeat (12) step(1'b0, 1'b0, 8'h00);
    chk_eq("b2b_starts", vstart.size(), 32'd2);
    if (vstart.size() == 2) chk_eq("b2b_period", vstart[1] - vstart[0], 32'd10);
    chk_eq("b2b_second_word", {24'd0, recv_m}, 32'h0000_00C3);

    repeat (600) step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6, 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
